// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch, decode, memory, ALU,
// branch and jump steps and drives the datapath select/strobe lines.
// Ports: clk, reset (sync, active-high), op[6:0], mem_ready;
//   outputs ALUOp, ALUSrcA, ALUSrcB, ResultSrc (2b each), AdrSrc, IRWrite,
//   PCUpdate, Branch, RegWrite, MemWrite, instr_done, and illegal_op
//   (only when ILLEGAL_TRAP_EN is defined).
// Option: ILLEGAL_TRAP_EN -- undefined opcodes park in TRAP until reset.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
`ifdef ILLEGAL_TRAP_EN
    output logic       instr_done,
    output logic       illegal_op
`else
    output logic       instr_done
`endif
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
`ifdef ILLEGAL_TRAP_EN
        JAL      = 4'd10,
        TRAP     = 4'd11
`else
        JAL      = 4'd10
`endif
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state;
    state_t next_state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky flag; TRAP never exits except through reset
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_op <= 1'b0;
        end else if (next_state == TRAP) begin
            illegal_op <= 1'b1;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW,
                    OP_SW:   next_state = MEMADR;
                    OP_R:    next_state = EXECR;
                    OP_I:    next_state = EXECI;
                    OP_BEQ:  next_state = BEQ;
                    OP_JAL:  next_state = JAL;
`ifdef ILLEGAL_TRAP_EN
                    default: next_state = TRAP;
`else
                    default: next_state = FETCH;
`endif
                endcase
            end
            MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = ALUWB;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     next_state = TRAP;
`endif
            default:  next_state = FETCH;
        endcase
    end

    // Retire pulse: last cycle of any non-fetch sequence
    assign instr_done = (state != FETCH) && (next_state == FETCH);

    // Output logic
    always_comb begin
        ALUOp     = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // Latch the instruction and bump PC only when memory answers
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_main_fsm.sv
// Directed testbench for main_fsm with an expected-output scoreboard.
// Define ILLEGAL_TRAP_EN to exercise the trap configuration.
module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCUpdate;
    logic       Branch;
    logic       RegWrite;
    logic       MemWrite;
    logic       instr_done;
    logic       ill;

    int checks = 0;
    int errors = 0;
    logic [15:0] q[$];

    localparam int S_F   = 0;
    localparam int S_DEC = 1;
    localparam int S_MA  = 2;
    localparam int S_MR  = 3;
    localparam int S_MWB = 4;
    localparam int S_MW  = 5;
    localparam int S_XR  = 6;
    localparam int S_XI  = 7;
    localparam int S_AWB = 8;
    localparam int S_BEQ = 9;
    localparam int S_JAL = 10;
    localparam int S_TRP = 11;

`ifdef ILLEGAL_TRAP_EN
    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .instr_done(instr_done), .illegal_op(ill)
    );
`else
    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .instr_done(instr_done)
    );
    assign ill = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a given state, from the control table
    function automatic logic [15:0] o(input int s, input logic mr,
                                      input logic d, input logic il);
        logic [1:0] aop, sa, sb, rs;
        logic adr, ir, pc, br, rw, mw;
        aop = 2'b00; sa = 2'b00; sb = 2'b00; rs = 2'b00;
        adr = 0; ir = 0; pc = 0; br = 0; rw = 0; mw = 0;
        case (s)
            S_F:   begin sb = 2'b10; rs = 2'b10; ir = mr; pc = mr; end
            S_DEC: begin sa = 2'b01; sb = 2'b01; end
            S_MA:  begin sa = 2'b10; sb = 2'b01; end
            S_MR:  begin adr = 1; end
            S_MWB: begin rs = 2'b01; rw = 1; end
            S_MW:  begin adr = 1; mw = 1; end
            S_XR:  begin sa = 2'b10; aop = 2'b10; end
            S_XI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            S_AWB: begin rw = 1; end
            S_BEQ: begin sa = 2'b10; aop = 2'b01; br = 1; end
            S_JAL: begin sa = 2'b01; sb = 2'b10; pc = 1; end
            default: begin end
        endcase
        return {aop, sa, sb, rs, adr, ir, pc, br, rw, mw, d, il};
    endfunction

    // One clock: drive inputs, queue expectation, check at negedge
    task automatic cyc(input logic rs, input logic mr,
                       input logic [15:0] e, input string tag);
        logic [15:0] obs;
        logic [15:0] exp;
        reset = rs;
        mem_ready = mr;
        q.push_back(e);
        @(negedge clk);
        obs = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
               PCUpdate, Branch, RegWrite, MemWrite, instr_done, ill};
        exp = q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        op = 7'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: FETCH, waiting for memory
        cyc(0, 0, o(S_F, 0, 0, 0), "reset_fetch");

        // lw, mem_ready high throughout (5 cycles)
        op = 7'b0000011;
        cyc(0, 1, o(S_F, 1, 0, 0), "lw_fetch");
        cyc(0, 1, o(S_DEC, 1, 0, 0), "lw_decode");
        cyc(0, 1, o(S_MA, 1, 0, 0), "lw_memadr");
        cyc(0, 1, o(S_MR, 1, 0, 0), "lw_memread");
        cyc(0, 1, o(S_MWB, 1, 1, 0), "lw_memwb");

        // FETCH stalls two cycles, then sw with 3 wait cycles
        op = 7'b0100011;
        cyc(0, 0, o(S_F, 0, 0, 0), "fetch_wait1");
        cyc(0, 0, o(S_F, 0, 0, 0), "fetch_wait2");
        cyc(0, 1, o(S_F, 1, 0, 0), "fetch_go");
        cyc(0, 1, o(S_DEC, 1, 0, 0), "sw_decode");
        cyc(0, 1, o(S_MA, 1, 0, 0), "sw_memadr");
        cyc(0, 0, o(S_MW, 0, 0, 0), "sw_wait1");
        cyc(0, 0, o(S_MW, 0, 0, 0), "sw_wait2");
        cyc(0, 0, o(S_MW, 0, 0, 0), "sw_wait3");
        cyc(0, 1, o(S_MW, 1, 1, 0), "sw_done");

        // R-type
        op = 7'b0110011;
        cyc(0, 1, o(S_F, 1, 0, 0), "r_fetch");
        cyc(0, 1, o(S_DEC, 1, 0, 0), "r_decode");
        cyc(0, 1, o(S_XR, 1, 0, 0), "r_execr");
        cyc(0, 1, o(S_AWB, 1, 1, 0), "r_aluwb");

        // I-type
        op = 7'b0010011;
        cyc(0, 1, o(S_F, 1, 0, 0), "i_fetch");
        cyc(0, 1, o(S_DEC, 1, 0, 0), "i_decode");
        cyc(0, 1, o(S_XI, 1, 0, 0), "i_execi");
        cyc(0, 1, o(S_AWB, 1, 1, 0), "i_aluwb");

        // jal
        op = 7'b1101111;
        cyc(0, 1, o(S_F, 1, 0, 0), "jal_fetch");
        cyc(0, 1, o(S_DEC, 1, 0, 0), "jal_decode");
        cyc(0, 1, o(S_JAL, 1, 0, 0), "jal_jal");
        cyc(0, 1, o(S_AWB, 1, 1, 0), "jal_aluwb");

        // beq
        op = 7'b1100011;
        cyc(0, 1, o(S_F, 1, 0, 0), "beq_fetch");
        cyc(0, 1, o(S_DEC, 1, 0, 0), "beq_decode");
        cyc(0, 1, o(S_BEQ, 1, 1, 0), "beq_beq");

        // Reset during EXECR: no ALUWB for that instruction
        op = 7'b0110011;
        cyc(0, 1, o(S_F, 1, 0, 0), "rst_r_fetch");
        cyc(0, 1, o(S_DEC, 1, 0, 0), "rst_r_decode");
        cyc(1, 1, o(S_XR, 1, 0, 0), "rst_r_execr");
        cyc(0, 0, o(S_F, 0, 0, 0), "rst_r_after");

        // Reset during a MEMREAD wait
        op = 7'b0000011;
        cyc(0, 1, o(S_F, 1, 0, 0), "rst_lw_fetch");
        cyc(0, 1, o(S_DEC, 1, 0, 0), "rst_lw_decode");
        cyc(0, 1, o(S_MA, 1, 0, 0), "rst_lw_memadr");
        cyc(0, 0, o(S_MR, 0, 0, 0), "rst_lw_wait");
        cyc(1, 0, o(S_MR, 0, 0, 0), "rst_lw_wait_rst");
        cyc(0, 0, o(S_F, 0, 0, 0), "rst_lw_after");

        // Illegal opcode
        op = 7'b1111111;
        cyc(0, 1, o(S_F, 1, 0, 0), "ill_fetch");
`ifdef ILLEGAL_TRAP_EN
        cyc(0, 1, o(S_DEC, 1, 0, 0), "ill_decode");
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, o(S_TRP, 1, 0, 1), "ill_trap");
        end
        cyc(1, 1, o(S_TRP, 1, 0, 1), "ill_trap_rst");
        cyc(0, 1, o(S_F, 1, 0, 0), "ill_after_rst");
`else
        cyc(0, 1, o(S_DEC, 1, 1, 0), "ill_decode");
        cyc(0, 1, o(S_F, 1, 0, 0), "ill_fetch_again");
`endif

        // Normal operation resumes
        op = 7'b1100011;
        cyc(0, 1, o(S_DEC, 1, 0, 0), "end_decode");
        cyc(0, 1, o(S_BEQ, 1, 1, 0), "end_beq");
        cyc(0, 0, o(S_F, 0, 0, 0), "end_fetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  opcode from the instruction register; stable from DECODE until the next FETCH completes.
REQ-005 mem_ready  input  1  memory handshake; the access presented this cycle completes when it is 1.
REQ-006 ALUOp  output  2  to alu_decoder: 00 add, 01 subtract, 10 funct-decoded.
REQ-007 ALUSrcA  output  2  00 PC, 01 OldPC, 10 register A.
REQ-008 ALUSrcB  output  2  00 register WD, 01 ImmExt, 10 constant 4.
REQ-009 ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-010 AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite  output  1 each  datapath strobes.
REQ-011 instr_done  output  1  single-cycle pulse when an instruction retires.
REQ-012 illegal_op  output  1  sticky illegal-opcode flag; present only under ILLEGAL_TRAP_EN.

Function
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, and TRAP (TRAP only under the macro).
REQ-014 Any output not listed for the current state SHALL be 0.
REQ-015 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=mem_ready (same-cycle); state holds while mem_ready=0 and moves to DECODE when mem_ready=1.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-017 DECODE next state: op 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other opcode -> FETCH (TRAP under the macro).
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op 0000011 -> MEMREAD, else -> MEMWRITE.
REQ-019 MEMREAD: AdrSrc=1, ResultSrc=00; holds until mem_ready=1, then -> MEMWB.
REQ-020 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-021 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held for every cycle of the wait; holds until mem_ready=1, then -> FETCH.
REQ-022 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both -> ALUWB.
REQ-023 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-024 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> FETCH.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; -> ALUWB.
REQ-026 instr_done SHALL be 1 exactly in the cycle the state register transitions into FETCH from a non-FETCH state; it is 0 while FETCH holds.
REQ-027 Cycle counts with mem_ready=1 throughout: lw 5, sw 4, R/I 4, jal 4, beq 3.
REQ-028 An unused state encoding SHALL go to FETCH on the next clock with all strobes 0.

Reset
REQ-029 While reset=1 at a rising edge, the state SHALL become FETCH and illegal_op SHALL become 0; reset overrides every transition, including a reset applied mid-instruction or mid-wait.
REQ-030 The first cycle after reset SHALL present the FETCH outputs; instr_done=0.

Configuration
REQ-031 The macro ILLEGAL_TRAP_EN SHALL control illegal-opcode handling.
REQ-032 When ILLEGAL_TRAP_EN is defined: an undefined opcode in DECODE -> TRAP; TRAP holds until reset with all strobes 0; illegal_op is set on entry and stays 1 until reset.
REQ-033 When ILLEGAL_TRAP_EN is undefined: an undefined opcode in DECODE -> FETCH with instr_done pulsed; illegal_op port and TRAP state are absent.

Verification
REQ-034 Reset, then op=0000011 with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in MEMWB; instr_done in cycle 5.
REQ-035 sw with mem_ready=0 for 3 MEMWRITE cycles -> MemWrite=1 for 4 consecutive cycles; single FETCH entry afterwards.
REQ-036 mem_ready=0 for 2 cycles in FETCH -> IRWrite=PCUpdate=0 for those cycles; both 1 only in the third cycle.
REQ-037 op=1100011 -> FETCH, DECODE, BEQ, FETCH; ALUOp=01 and Branch=1 only in BEQ.
REQ-038 reset asserted during EXECR -> next state FETCH; RegWrite never asserted for that instruction.
REQ-039 op=1111111 -> TRAP with illegal_op=1 held for 10 cycles (macro on); FETCH with instr_done pulse (macro off).
